// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Circular byte FIFO that feeds uart_tx one byte at a time using a
//            start-pulse / done-tick handshake.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clr_overflow,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_done_tick,
    output logic                  tx_busy
);

    localparam int                  c_depth      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_full_count = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_cnt_one    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one  = ADDR_WIDTH'(1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_wait = 1'b1;

    logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic [0:0]            r_state;
    logic                  r_tx_start;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_busy;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [0:0]            w_state_next;
    logic                  w_start_next;
    logic                  w_busy_next;

    // full/empty come from the count held at the start of the cycle, so a
    // write into a full FIFO is dropped even when a pop happens alongside it.
    assign w_full  = (r_count == c_full_count);
    assign w_empty = (r_count == '0);
    assign w_push  = wr_en && !w_full;

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_start_next = 1'b0;
        w_busy_next  = r_tx_busy;
        case (r_state)
            c_st_idle: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_start_next = 1'b1;
                    w_busy_next  = 1'b1;
                    w_state_next = c_st_wait;
                end
            end
            c_st_wait: begin
                if (tx_done_tick) begin
                    w_busy_next  = 1'b0;
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // A dropped write beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (wr_en && w_full) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_tx_busy  <= 1'b0;
        end else begin
            r_tx_start <= w_start_next;
            r_tx_busy  <= w_busy_next;
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign tx_busy  = r_tx_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Self-checking bench for uart_tx_fifo with a queue-based model and
//            a randomized uart_tx responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          clr_overflow;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          tx_done_tick;
    logic          tx_busy;

    logic auto_pulse = 1'b0;
    logic man_done   = 1'b0;
    assign tx_done_tick = auto_pulse | man_done;

    uart_tx_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .clr_overflow (clr_overflow),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done_tick (tx_done_tick),
        .tx_busy      (tx_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;
    bit auto_en  = 1'b0;
    int dmin     = 1;
    int dmax     = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a byte queue plus an "outstanding byte" flag.
    logic [DW-1:0] m_q[$];
    bit            m_busy  = 1'b0;
    bit            m_start = 1'b0;
    bit            m_ovf   = 1'b0;
    logic [DW-1:0] m_data  = '0;
    int            m_accepted = 0;
    int            m_popped   = 0;

    always @(posedge clk) begin : model
        bit was_full;
        bit do_pop;
        if (reset) begin
            m_q.delete();
            m_busy  = 1'b0;
            m_start = 1'b0;
            m_ovf   = 1'b0;
            m_data  = '0;
        end else begin
            was_full = (m_q.size() == DEPTH);
            do_pop   = !m_busy && (m_q.size() != 0);
            m_start  = 1'b0;
            if (do_pop) begin
                m_data  = m_q.pop_front();
                m_start = 1'b1;
                m_busy  = 1'b1;
                m_popped++;
            end else if (m_busy && tx_done_tick) begin
                m_busy = 1'b0;
            end
            if (wr_en && was_full) begin
                m_ovf = 1'b1;
            end else begin
                if (wr_en) begin
                    m_q.push_back(wr_data);
                    m_accepted++;
                end
                if (clr_overflow) m_ovf = 1'b0;
            end
        end
    end

    // Cycle-by-cycle compare plus logging for the directed checks.
    bit            log_en    = 1'b0;
    bit            prev_busy = 1'b0;
    int            n_starts  = 0;
    logic [DW-1:0] start_log[$];
    int            start_cyc[$];
    int            done_cyc[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("count",    32'(count),    32'(m_q.size()));
            check("full",     32'(full),     32'(m_q.size() == DEPTH));
            check("empty",    32'(empty),    32'(m_q.size() == 0));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("tx_start", 32'(tx_start), 32'(m_start));
            check("tx_busy",  32'(tx_busy),  32'(m_busy));
            check("tx_data",  32'(tx_data),  32'(m_data));
            if (tx_start) begin
                check("start_while_busy", 32'(prev_busy), 32'd0);
                n_starts++;
                if (log_en) begin
                    start_log.push_back(tx_data);
                    start_cyc.push_back(cyc);
                end
            end
            if (log_en && tx_done_tick) done_cyc.push_back(cyc);
        end
        prev_busy = tx_busy;
    end

    // uart_tx stand-in: answers each start with a done tick after a delay.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_en && tx_start) begin
                repeat ($urandom_range(dmax, dmin)) @(posedge clk);
                #1 auto_pulse = 1'b1;
                @(posedge clk);
                #1 auto_pulse = 1'b0;
            end
        end
    end

    task automatic clear_logs();
        start_log.delete();
        start_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic pulse_done();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int t;
        t = 0;
        while (!(empty && !tx_busy) && t < budget) begin
            tick();
            t++;
        end
        check(name, 32'(t < budget), 32'd1);
    endtask

    initial begin
        int n;
        int s0;
        int t;
        int k;
        int acc0;
        bit seen_ee;

        reset        = 1'b1;
        wr_en        = 1'b0;
        wr_data      = '0;
        clr_overflow = 1'b0;
        repeat (3) tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset / idle
        @(negedge clk);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_busy",  32'(tx_busy),  32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        s0 = n_starts;
        repeat (50) tick();
        check("idle_no_start", 32'(n_starts - s0), 32'd0);

        // Single byte latency
        wr_en   = 1'b1;
        wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        n = cyc;
        @(negedge clk);
        check("single_no_early_start", 32'(tx_start), 32'd0);
        check("single_empty_fell",     32'(empty),    32'd0);
        @(negedge clk);
        check("single_start_edge",     32'(tx_start), 32'd1);
        check("single_start_cycle",    32'(cyc - n),  32'd1);
        check("single_data",           32'(tx_data),  32'h55);
        @(negedge clk);
        check("single_start_one_cyc",  32'(tx_start), 32'd0);
        check("single_busy",           32'(tx_busy),  32'd1);
        repeat (100) tick();
        pulse_done();
        @(negedge clk);
        check("single_busy_fell",      32'(tx_busy),  32'd0);
        check("single_empty_after",    32'(empty),    32'd1);
        check("single_data_held",      32'(tx_data),  32'h55);

        // Burst ordering with fixed 20-cycle frames
        tick();
        clear_logs();
        log_en  = 1'b1;
        dmin    = 20;
        dmax    = 20;
        auto_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        t = 0;
        while (!(start_log.size() == 16 && !tx_busy) && t < 1000) begin
            tick();
            t++;
        end
        check("burst_timeout", 32'(t < 1000), 32'd1);
        check("burst_starts",  32'(start_log.size()), 32'd16);
        check("burst_dones",   32'(done_cyc.size()),  32'd16);
        if (start_log.size() == 16 && done_cyc.size() >= 15) begin
            for (int i = 0; i < 16; i++) check("burst_order", 32'(start_log[i]), 32'(i + 1));
            for (int i = 0; i < 15; i++) check("burst_gap", 32'(start_cyc[i+1] - done_cyc[i]), 32'd2);
        end
        check("burst_overflow", 32'(overflow), 32'd0);
        log_en  = 1'b0;
        auto_en = 1'b0;

        // Full / overflow with the first byte held outstanding
        tick();
        clear_logs();
        log_en = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            wr_en   = 1'b1;
            wr_data = (i == 18) ? 8'hEE : 8'(8'hA0 + i);
            tick();
        end
        wr_en = 1'b0;
        @(negedge clk);
        check("full_count",    32'(count),    32'd16);
        check("full_flag",     32'(full),     32'd1);
        check("full_overflow", 32'(overflow), 32'd1);
        check("full_busy",     32'(tx_busy),  32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 32'(overflow), 32'd0);
        dmin    = 3;
        dmax    = 3;
        auto_en = 1'b1;
        pulse_done();
        drain("full_drain_timeout", 2000);
        auto_en = 1'b0;
        log_en  = 1'b0;
        check("full_total_starts", 32'(start_log.size()), 32'd17);
        seen_ee = 1'b0;
        foreach (start_log[i]) if (start_log[i] == 8'hEE) seen_ee = 1'b1;
        check("dropped_not_sent", 32'(seen_ee), 32'd0);
        if (start_log.size() == 17) begin
            for (int i = 0; i < 17; i++) check("full_order", 32'(start_log[i]), 32'(8'hA1 + i));
        end

        // Wrap and simultaneous access under random traffic
        tick();
        s0      = n_starts;
        acc0    = m_accepted;
        dmin    = 1;
        dmax    = 30;
        auto_en = 1'b1;
        k = 0;
        while (k < 40) begin
            wr_en        = (k < 20) ? 1'b1 : 1'($urandom_range(1, 0));
            wr_data      = 8'($urandom);
            clr_overflow = 1'($urandom_range(7, 0) == 0);
            if (wr_en) k++;
            tick();
        end
        wr_en        = 1'b0;
        clr_overflow = 1'b0;
        drain("wrap_drain_timeout", 3000);
        auto_en = 1'b0;
        check("wrap_starts_eq_accepted", 32'(n_starts - s0), 32'(m_accepted - acc0));

        // Reset during WAIT with words queued
        tick();
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h30 + i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        @(negedge clk);
        check("mid_busy",  32'(tx_busy), 32'd1);
        check("mid_count", 32'(count),   32'd5);
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mrst_count",    32'(count),    32'd0);
        check("mrst_empty",    32'(empty),    32'd1);
        check("mrst_full",     32'(full),     32'd0);
        check("mrst_busy",     32'(tx_busy),  32'd0);
        check("mrst_start",    32'(tx_start), 32'd0);
        check("mrst_data",     32'(tx_data),  32'd0);
        check("mrst_overflow", 32'(overflow), 32'd0);
        s0 = n_starts;
        tick();
        pulse_done();
        repeat (30) tick();
        @(negedge clk);
        check("mrst_no_start",   32'(n_starts - s0), 32'd0);
        check("mrst_stray_done", 32'(tx_busy),       32'd0);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
